// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding definitions for the instruction loader and the decoder:
// kinds, opcodes, ctrl codes, FSM states and the ALU funct3 mapping.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    K_ALU_R  = 3'd0,
    K_ALU_I  = 3'd1,
    K_MUL    = 3'd2,
    K_LOAD   = 3'd3,
    K_STORE  = 3'd4,
    K_BRANCH = 3'd5,
    K_JAL    = 3'd6,
    K_JALR   = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_MUL    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // ALU ctrl codes
  localparam logic [4:0] C_ADD  = 5'd0;
  localparam logic [4:0] C_SUB  = 5'd1;
  localparam logic [4:0] C_AND  = 5'd2;
  localparam logic [4:0] C_OR   = 5'd3;
  localparam logic [4:0] C_XOR  = 5'd4;
  localparam logic [4:0] C_SLL  = 5'd5;
  localparam logic [4:0] C_SRL  = 5'd6;
  localparam logic [4:0] C_SRA  = 5'd7;
  localparam logic [4:0] C_SLTU = 5'd8;
  localparam logic [4:0] C_SLT  = 5'd9;
  // MUL family occupies 0xA..0x11, funct3 = ctrl - C_MUL_BASE
  localparam logic [4:0] C_MUL_BASE = 5'd10;
  localparam logic [4:0] C_MUL_LAST = 5'd17;
  // Branch ctrl codes
  localparam logic [4:0] C_BEQ  = 5'd0;
  localparam logic [4:0] C_BNE  = 5'd1;
  localparam logic [4:0] C_BLT  = 5'd2;
  localparam logic [4:0] C_BGE  = 5'd3;
  localparam logic [4:0] C_BLTU = 5'd4;
  localparam logic [4:0] C_BGEU = 5'd5;

  typedef struct packed {
    logic       ok;
    logic       alt;  // bit30 variant (SUB / SRA)
    logic [2:0] f3;
  } alu_enc_t;

  function automatic alu_enc_t alu_funct(input logic [4:0] ctrl);
    alu_enc_t e;
    e = '{ok: 1'b1, alt: 1'b0, f3: 3'b000};
    case (ctrl)
      C_ADD:   e.f3 = 3'b000;
      C_SUB:   begin e.f3 = 3'b000; e.alt = 1'b1; end
      C_XOR:   e.f3 = 3'b100;
      C_OR:    e.f3 = 3'b110;
      C_AND:   e.f3 = 3'b111;
      C_SLL:   e.f3 = 3'b001;
      C_SRL:   e.f3 = 3'b101;
      C_SRA:   begin e.f3 = 3'b101; e.alt = 1'b1; end
      C_SLT:   e.f3 = 3'b010;
      C_SLTU:  e.f3 = 3'b011;
      default: e.ok = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Instruction-field handshake plus the instruction-memory write port.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  import instr_encoder_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  kind_e             in_kind;
  logic [4:0]        in_ctrl;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [20:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_kind, in_ctrl, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_ctrl, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit RV32IM word for one beat
// and flags illegal ctrl codes or out-of-range / misaligned immediates.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  kind_e       kind,
  input  logic [4:0]  ctrl,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  logic     fits12;
  logic     fits13;
  alu_enc_t alu;
  logic [4:0] mul_f3;
  logic [2:0] br_f3;
  logic       br_ok;

  // Signed range holds when all bits above the field's sign bit match it.
  assign fits12 = (&imm[20:11]) | ~(|imm[20:11]);
  assign fits13 = (&imm[20:12]) | ~(|imm[20:12]);
  assign alu    = alu_funct(ctrl);
  assign mul_f3 = ctrl - C_MUL_BASE;

  always_comb begin
    br_ok = 1'b1;
    br_f3 = 3'b000;
    case (ctrl)
      C_BEQ:   br_f3 = 3'b000;
      C_BNE:   br_f3 = 3'b001;
      C_BLT:   br_f3 = 3'b100;
      C_BGE:   br_f3 = 3'b101;
      C_BLTU:  br_f3 = 3'b110;
      C_BGEU:  br_f3 = 3'b111;
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    word = 32'h0;
    bad  = 1'b0;
    case (kind)
      K_ALU_R: begin
        bad  = ~alu.ok;
        word = {alu.alt ? F7_ALT : F7_BASE, rs2, rs1, alu.f3, rd, OP_ALU_R};
      end
      K_ALU_I: begin
        bad  = ~alu.ok | alu.alt | ~fits12;
        word = {imm[11:0], rs1, alu.f3, rd, OP_ALU_I};
      end
      K_MUL: begin
        bad  = (ctrl < C_MUL_BASE) | (ctrl > C_MUL_LAST);
        word = {F7_MUL, rs2, rs1, mul_f3[2:0], rd, OP_MUL};
      end
      K_LOAD: begin
        bad  = ~fits12;
        word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      end
      K_STORE: begin
        bad  = ~fits12;
        word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      end
      K_BRANCH: begin
        bad  = ~br_ok | ~fits13 | imm[0];
        word = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], OP_BRANCH};
      end
      K_JAL: begin
        bad  = imm[0];
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      K_JALR: begin
        bad  = ~fits12;
        word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      end
      default: begin
        bad  = 1'b1;
        word = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Load-session FSM: accepts instruction fields, encodes them through
// instr_pack and writes one word per cycle into instruction memory.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  finish,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W:0]       words
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_e            state_reg, state_next;
  logic [ADDR_W:0]   words_reg, words_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic [31:0]       pack_word;
  logic              pack_bad;
  logic              accept;

  instr_pack u_pack (
    .kind (bus.in_kind),
    .ctrl (bus.in_ctrl),
    .rd   (bus.in_rd),
    .rs1  (bus.in_rs1),
    .rs2  (bus.in_rs2),
    .imm  (bus.in_imm),
    .word (pack_word),
    .bad  (pack_bad)
  );

  assign bus.in_ready  = (state_reg == S_LOAD) && (words_reg < DEPTH_W);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.imem_we   = we_reg;
  assign bus.imem_addr = addr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign busy  = (state_reg == S_LOAD);
  assign done  = (state_reg == S_DONE);
  assign err   = err_reg;
  assign words = words_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      words_reg <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      words_reg <= words_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    words_next = words_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_LOAD;
          words_next = '0;
        end
      end
      S_LOAD: begin
        // A restart drops whatever beat arrives alongside it.
        if (start) begin
          words_next = '0;
        end else begin
          if (accept) begin
            if (pack_bad) begin
              err_next = 1'b1;
            end else begin
              we_next    = 1'b1;
              addr_next  = words_reg[ADDR_W-1:0];
              wdata_next = pack_word;
              words_next = words_reg + 1'b1;
            end
          end
          if (finish || (words_next == DEPTH_W))
            state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with hand-encoded RV32IM words.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            finish;
  logic            busy;
  logic            done;
  logic            err;
  logic [ADDR_W:0] words;
  int              total = 0;
  int              bad = 0;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .finish (finish),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .words  (words)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input kind_e k, input logic [4:0] c, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm);
    bus.in_kind = k;
    bus.in_ctrl = c;
    bus.in_rd   = rd;
    bus.in_rs1  = rs1;
    bus.in_rs2  = rs2;
    bus.in_imm  = imm;
  endtask

  task automatic beat(input kind_e k, input logic [4:0] c, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm);
    set_fields(k, c, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int addr, input logic [31:0] data);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd1);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'(addr));
    check({tag, "_wdata"}, bus.imem_wdata, data);
  endtask

  task automatic expect_reject(input string tag, input int words_exp);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_words"}, 32'(words), 32'(words_exp));
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_words"}, 32'(words), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    finish = 1'b0;
    bus.in_valid = 1'b0;
    set_fields(K_ALU_R, 5'd0, 5'd0, 5'd0, 5'd0, 21'd0);
    tick();
    tick();
    expect_reset("rst");
    rst = 1'b0;

    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(bus.in_ready), 32'd1);
    check("start_words", 32'(words), 32'd0);

    beat(K_ALU_R, 5'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    expect_write("add", 0, 32'h002081B3);
    beat(K_ALU_R, 5'd1, 5'd3, 5'd1, 5'd2, 21'd0);
    expect_write("sub", 1, 32'h402081B3);
    beat(K_BRANCH, 5'd0, 5'd0, 5'd1, 5'd2, 21'd8);
    expect_write("beq", 2, 32'h00208463);
    beat(K_JAL, 5'd0, 5'd1, 5'd0, 5'd0, 21'd16);
    expect_write("jal", 3, 32'h010000EF);

    beat(K_BRANCH, 5'd0, 5'd0, 5'd1, 5'd2, 21'd7);
    expect_reject("br_odd", 4);
    tick();
    check("br_odd_err_clear", 32'(err), 32'd0);
    beat(K_ALU_I, 5'd0, 5'd1, 5'd0, 5'd0, 21'd5);
    expect_write("addi", 4, 32'h00500093);

    beat(K_ALU_I, 5'd1, 5'd1, 5'd0, 5'd0, 21'd5);
    expect_reject("alui_sub", 5);
    beat(K_ALU_I, 5'd0, 5'd1, 5'd0, 5'd0, 21'd2048);
    expect_reject("alui_range", 5);
    beat(K_BRANCH, 5'd6, 5'd0, 5'd1, 5'd2, 21'd8);
    expect_reject("br_ctrl", 5);

    beat(K_STORE, 5'd0, 5'd0, 5'd1, 5'd2, 21'd8);
    expect_write("sw", 5, 32'h0020A423);
    beat(K_MUL, 5'd10, 5'd3, 5'd1, 5'd2, 21'd0);
    expect_write("mul", 6, 32'h022081B3);

    // finish together with an accepted beat: beat written, then DONE
    set_fields(K_ALU_R, 5'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    bus.in_valid = 1'b1;
    finish = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    finish = 1'b0;
    expect_write("fin_beat", 7, 32'h002081B3);
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_words", 32'(words), 32'd8);

    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("done_ignore_we", 32'(bus.imem_we), 32'd0);
    check("done_ignore_words", 32'(words), 32'd8);

    start = 1'b1;
    finish = 1'b1;
    tick();
    start = 1'b0;
    finish = 1'b0;
    check("sf_busy", 32'(busy), 32'd1);
    check("sf_done", 32'(done), 32'd0);
    check("sf_words", 32'(words), 32'd0);

    beat(K_ALU_R, 5'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    expect_write("pre_restart", 0, 32'h002081B3);
    bus.in_valid = 1'b1;
    start = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    start = 1'b0;
    check("restart_we", 32'(bus.imem_we), 32'd0);
    check("restart_words", 32'(words), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);

    // fill all 64 words back to back, rd = index mod 32
    set_fields(K_ALU_R, 5'd0, 5'd0, 5'd1, 5'd2, 21'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      logic [4:0] rd_i;
      rd_i = 5'(i);
      bus.in_rd = rd_i;
      tick();
      expect_write($sformatf("fill%0d", i), i, {7'b0, 5'd2, 5'd1, 3'b000, rd_i, 7'b0110011});
    end
    check("full_ready", 32'(bus.in_ready), 32'd0);
    check("full_done", 32'(done), 32'd1);
    check("full_words", 32'(words), 32'd64);
    tick();
    bus.in_valid = 1'b0;
    check("full_no_we", 32'(bus.imem_we), 32'd0);

    // reset the cycle after an accept
    pulse_start();
    beat(K_ALU_R, 5'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    expect_write("pre_rst", 0, 32'h002081B3);
    rst = 1'b1;
    tick();
    expect_reset("rst_after");
    rst = 1'b0;

    // reset on the accepting edge discards the word
    pulse_start();
    set_fields(K_ALU_R, 5'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    expect_reset("rst_inflight");
    tick();
    check("rst_inflight_we2", 32'(bus.imem_we), 32'd0);

    pulse_start();
    beat(K_JALR, 5'd0, 5'd1, 5'd2, 5'd0, 21'h1FFFFC);
    expect_write("reload_jalr", 0, 32'hFFC100E7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameters SHALL be: DEPTH, default 64, instruction-memory words; ADDR_W, default 6, equal to clog2(DEPTH).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  pulse; opens a load session at address 0.
REQ-005 finish  input  1  pulse; closes the session early.
REQ-006 in_valid / in_ready  input / output  1 / 1  instruction-field handshake.
REQ-007 in_kind  input  3  0 ALU_R, 1 ALU_I, 2 MUL, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR.
REQ-008 in_ctrl  input  5  operation code, using the same control numbering the decoder emits.
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-010 in_imm  input  21  signed immediate, in bytes for BRANCH and JAL.
REQ-011 imem_we, imem_addr, imem_wdata  output  1, ADDR_W, 32  instruction-memory write port.
REQ-012 busy, done, err  output  1 each  session active; session complete (level); encode-error pulse.
REQ-013 words  output  ADDR_W+1  count of words written this session.

Function
REQ-014 FSM states SHALL be IDLE, LOAD and DONE.
- IDLE to LOAD: on start.
- LOAD to DONE: on finish, or on words reaching DEPTH.
- DONE to LOAD: on start.
REQ-015 in_ready SHALL equal (state==LOAD) AND (words<DEPTH); in_valid is ignored in IDLE and DONE.
REQ-016 An accepted beat (in_valid AND in_ready at an edge) SHALL produce registered imem_we=1 with imem_addr=words-before-accept in the next cycle; latency is 1 cycle and throughput is one word per cycle.
REQ-017 Opcodes SHALL be:
- ALU_R 0110011; ALU_I 0010011; MUL 0110011; LOAD 0000011.
- STORE 0100011; BRANCH 1100011; JAL 1101111; JALR 1100111.
REQ-018 ALU_R/ALU_I ctrl-to-funct3 mapping SHALL be:
- 0 to 000; 1 to 000 with bit30 set (ALU_R only).
- 4 to 100; 3 to 110; 2 to 111; 5 to 001.
- 6 to 101; 7 to 101 with bit30 set.
- 9 to 010; 8 to 011.
REQ-019 MUL ctrl 0xA..0x11 SHALL map to funct3 0..7 with funct7=0000001; BRANCH ctrl 0..5 SHALL map to funct3 000,001,100,101,110,111.
REQ-020 LOAD and STORE SHALL use funct3=010; JALR SHALL use funct3=000.
REQ-021 Immediate packing SHALL be:
- I-type: imm[11:0] at 31:20.
- S-type: imm[11:5] at 31:25, imm[4:0] at 11:7.
- B-type: imm[12|10:5] at 31:25, imm[4:1|11] at 11:7.
- J-type: imm[20|10:1|11|19:12] at 31:12.
REQ-022 Encode error SHALL be flagged for any of:
- a ctrl not listed for its kind;
- an I/S/B immediate outside the 12/12/13-bit signed range;
- an odd BRANCH or JAL immediate;
- ctrl=1 or 7 with kind ALU_I.
REQ-023 On encode error the beat SHALL still be consumed: err=1 for one cycle, imem_we=0, words unchanged.
REQ-024 words SHALL increment by 1 per successful write and SHALL never exceed DEPTH; there is no wrap-around.
REQ-025 busy SHALL equal (state==LOAD); done SHALL be high in DONE.
REQ-026 When start and finish are asserted in the same cycle, start SHALL win.
REQ-027 When finish coincides with an accepted beat, that beat SHALL still be written and the FSM SHALL then enter DONE.
REQ-028 start in LOAD SHALL restart the session: words=0, and any beat accepted in the same cycle is dropped.

Reset
REQ-029 On rst the FSM SHALL enter IDLE and outputs SHALL reset to: imem_we=0, imem_addr=0, imem_wdata=0, words=0, err=0, busy=0, done=0, in_ready=0.
REQ-030 rst during LOAD SHALL discard the in-flight word; no write is issued in the cycle after reset.

Structure
REQ-031 The kind enumeration, opcode constants, ctrl codes and FSM state encoding SHALL live in a shared package, also used by the decoder.
REQ-032 Field packing and error checking SHALL be one combinational sub-module, instr_pack, with the registered FSM and counter in instr_encoder_loader.

Verification
REQ-033 ALU_R ctrl0 rd3 rs1=1 rs2=2, then ctrl1 with the same fields -> imem_wdata 0x002081B3 at addr 0, then 0x402081B3 at addr 1.
REQ-034 BRANCH ctrl0 rs1=1 rs2=2 imm=8 -> 0x00208463; JAL rd=1 imm=16 -> 0x010000EF.
REQ-035 BRANCH imm=7 -> err pulse for one cycle, imem_we=0, words unchanged, next valid beat written at the same address.
REQ-036 64 back-to-back beats -> 64 writes at addresses 0..63, then in_ready=0, done=1, words=64.
REQ-037 rst asserted the cycle after an accept -> no imem_we, all outputs at reset values; start then reloads from addr 0.
REQ-038 start and finish asserted together in DONE -> LOAD entered, busy=1, words=0.
